// File: rtl/led_pwm_driver.sv
// LED pin output stage: active-low pin with 8-bit PWM brightness and an optional
// hardware blink, both configured through a small byte-wide register file.
//
// state  | meaning
// IDLE   | LED off, waiting for led_req
// STEADY | LED on at PWM brightness, no blink
// BLINK  | LED alternates on/off every period x PRESCALE cycles, on-phase first

module led_pwm_driver #(
    parameter int PRESCALE = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       led_req,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       led_pin,
    output logic       blink_wrap
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEADY = 2'd1,
        BLINK  = 2'd2
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    state_t      state;
    logic [7:0]  duty;
    logic [7:0]  period;
    logic [7:0]  pwm_cnt;
    logic [7:0]  blink_cnt;
    logic [15:0] presc_cnt;
    logic        phase;
    logic        wrap_evt;

    logic tick;
    logic pwm_on;
    logic lit;
    logic wr_duty;
    logic wr_period;
    logic period_set;
    logic blink_restart;
    logic blink_step;

    always_comb begin
        tick       = (presc_cnt == PRESC_LAST);
        pwm_on     = (duty == 8'hFF) || (pwm_cnt < duty);
        lit        = pwm_on && ((state == STEADY) || ((state == BLINK) && phase));
        wr_duty    = data_write && (address == 4'h0);
        wr_period  = data_write && (address == 4'h1);
        period_set = (period != 8'h00);
        // Entering BLINK, or rewriting a nonzero period while blinking, restarts the on-phase.
        blink_restart = led_req && period_set &&
                        ((state != BLINK) || (wr_period && (data_in != 8'h00)));
        blink_step    = led_req && period_set && (state == BLINK) && !blink_restart && tick;
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = duty;
            4'h1:    data_out = period;
            // Phase is only meaningful while blinking, so it reads as 0 elsewhere.
            4'h2:    data_out = {4'b0000, state, phase & (state == BLINK), led_req};
            default: data_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            duty       <= 8'hFF;
            period     <= 8'h00;
            pwm_cnt    <= 8'h00;
            presc_cnt  <= 16'h0000;
            blink_cnt  <= 8'h00;
            phase      <= 1'b1;
            wrap_evt   <= 1'b0;
            led_pin    <= 1'b1;
            blink_wrap <= 1'b0;
        end else begin
            if (wr_duty) begin
                duty <= data_in;
            end
            if (wr_period) begin
                period <= data_in;
            end

            pwm_cnt    <= pwm_cnt + 8'd1;
            led_pin    <= ~lit;
            blink_wrap <= wrap_evt;
            wrap_evt   <= 1'b0;

            case (state)
                IDLE: begin
                    if (led_req) begin
                        state <= period_set ? BLINK : STEADY;
                    end
                end
                STEADY: begin
                    if (!led_req) begin
                        state <= IDLE;
                    end else if (period_set) begin
                        state <= BLINK;
                    end
                end
                BLINK: begin
                    if (!led_req) begin
                        state <= IDLE;
                    end else if (!period_set) begin
                        state <= STEADY;
                    end
                end
                default: state <= IDLE;
            endcase

            if (blink_restart) begin
                presc_cnt <= 16'h0000;
                blink_cnt <= 8'h00;
                phase     <= 1'b1;
            end else begin
                presc_cnt <= tick ? 16'h0000 : presc_cnt + 16'd1;
                if (blink_step) begin
                    if (blink_cnt == period - 8'd1) begin
                        blink_cnt <= 8'h00;
                        phase     <= ~phase;
                        wrap_evt  <= 1'b1;
                    end else begin
                        blink_cnt <= blink_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Output stage between the LED control peripheral and the FPGA LED pin. It takes the peripheral's on/off request and turns it into the physical, active-low pin waveform. It adds 8-bit PWM brightness and an optional hardware blink, both programmed through a byte register interface on the same peripheral bus.

## Interface
- `PRESCALE`, default 12000: clk cycles per blink tick (1 kHz at 12 MHz); legal range 2..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `led_req`  in  1  on/off request from the LED control peripheral; 1 = LED on.
- `address`  in  4  register address.
- `data_write`  in  1  write strobe; one write per cycle when high.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data; combinational from `address`.
- `led_pin`  out  1  LED pin, active-low (0 = lit); registered.
- `blink_wrap`  out  1  one-cycle pulse on every blink phase toggle; registered.

## Operation
- Registers:
  - 0x0 `duty`, R/W, reset 0xFF.
  - 0x1 `period` in ticks, R/W, reset 0x00; 0 = no blink.
  - 0x2 status, RO: {4'b0, state[1:0], phase, led_req}.
  - Other addresses read 0x00. Writes to 0x2 and unmapped addresses are ignored.
- Prescaler: 16-bit counter runs 0..PRESCALE-1. `tick` is high when the count equals PRESCALE-1, and the counter wraps to 0 on the next cycle.
- PWM counter: 8-bit free-running counter that advances every clk and wraps 255 -> 0.
  - `pwm_on` = (duty == 255) || (pwm_cnt < duty).
  - duty 0 never lights the LED; duty 255 is constant on.
- Blink counter: 8-bit, advances on `tick` in BLINK only.
  - On `tick` with blink_cnt == period-1: blink_cnt <= 0, phase toggles, blink_wrap pulses.
- FSM, state encoding IDLE=0, STEADY=1, BLINK=2:
  - IDLE: if led_req=1 and period=0, go to STEADY. If led_req=1 and period≠0, go to BLINK.
  - STEADY: if led_req=0, go to IDLE. If period becomes ≠0, go to BLINK.
  - BLINK: if led_req=0, go to IDLE. If period becomes 0, go to STEADY.
  - Every entry into BLINK clears the prescaler and blink_cnt and sets phase=1. The first on-phase is therefore exactly period×PRESCALE cycles.
  - A write to `period` while in BLINK with a nonzero value also restarts the blink: prescaler=0, blink_cnt=0, phase=1.
- `lit` = (state==STEADY && pwm_on) || (state==BLINK && phase && pwm_on).
- Pin update: `led_pin` <= ~lit, registered every cycle.
- Duty change: a `duty` write takes effect at the next PWM compare (next cycle) and does not reset pwm_cnt.
- Write and state change in the same cycle: the register write completes first, and the FSM transition uses the old register value. The new value governs from the following cycle.
- Reset state: state=IDLE, duty=0xFF, period=0, all counters 0, phase=1, led_pin=1 (off), blink_wrap=0. Asserting `rst` mid-blink forces these values immediately and asynchronously.

## Timing
- led_req rise sampled at edge N: state changes at N+1, led_pin changes at N+2 (2-cycle latency). The same latency applies to led_req fall.
- Register write at edge N: register updates at N; `data_out` shows the new value after N.
- Blink on/off phase lengths: exactly period×PRESCALE cycles each.
- PWM period: 256 cycles, low time = duty cycles.
- blink_wrap aligns with the cycle in which phase toggles, seen at the output one cycle later alongside led_pin.

## Test plan
All tests use PRESCALE=4.
- Reset: assert rst mid-cycle.
  - Expect led_pin=1, blink_wrap=0, data_out@0x0=0xFF, @0x1=0x00 immediately, with no clk edge required.
- Steady on: duty=0xFF, period=0, led_req 0->1 at edge N.
  - Expect led_pin=0 from N+2 and status=0x05. Then led_req->0 and expect led_pin=1 two cycles later.
- PWM: duty=0x40, steady on.
  - Expect led_pin low 64 and high 192 cycles of every 256.
  - duty=0x00: expect led_pin stuck at 1.
- Blink: period=3, duty=0xFF, led_req=1.
  - Expect led_pin alternating 12 cycles low, 12 cycles high, with a blink_wrap pulse at each toggle.
- Mid-blink period write: write period=5 during an off phase.
  - Expect led_pin low on the next cycle, then 20-cycle phases.
  - Write period=0: expect status state=STEADY and led_pin steady low.
- Simultaneous events: led_req falls in the same cycle as a period write.
  - Expect state=IDLE, period register updated, and led_pin=1 two cycles later.
